// File: rtl/period_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter_if
//  Description : Signal bundle between the measured source and the period
//                meter: the input under measurement plus the result outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface period_meter_if #(
    parameter int W       = 16,
    parameter int N_WIDTH = 8
);
    logic               sig_in;
    logic [W-1:0]       period;
    logic [W-1:0]       high_time;
    logic               valid;
    logic               timeout;
    logic [N_WIDTH-1:0] meas_count;

    // Source side: drives the signal, observes the results
    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout,
        input  meas_count
    );

    // Meter side: samples the signal, produces the results
    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output timeout,
        output meas_count
    );
endinterface
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter
//  Description : Measures the period and high time of an asynchronous input
//                in clk cycles, between consecutive rising edges. Flags a
//                sticky timeout when no edge arrives before the counter would
//                saturate, and counts completed measurements.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
    parameter int W       = 16,
    parameter int N_WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    period_meter_if.slave      bus
);

    localparam logic [0:0]         c_WAIT_FIRST = 1'b0;
    localparam logic [0:0]         c_MEASURE    = 1'b1;
    localparam logic [W-1:0]       c_CNT_MAX    = {W{1'b1}};
    localparam logic [W-1:0]       c_ONE_W      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N_WIDTH-1:0] c_ONE_N      = {{(N_WIDTH-1){1'b0}}, 1'b1};

    // Synchronizer chain and edge-history register
    logic r_s1_q,    w_s1_d;
    logic r_s_q,     w_s_d;
    logic r_s_dly_q, w_s_dly_d;

    // Measurement state
    logic [0:0]         r_state_q,      w_state_d;
    logic [W-1:0]       r_cnt_q,        w_cnt_d;
    logic [W-1:0]       r_hi_cnt_q,     w_hi_cnt_d;
    logic [W-1:0]       r_period_q,     w_period_d;
    logic [W-1:0]       r_high_time_q,  w_high_time_d;
    logic               r_valid_q,      w_valid_d;
    logic               r_timeout_q,    w_timeout_d;
    logic [N_WIDTH-1:0] r_meas_count_q, w_meas_count_d;

    logic w_edge;

    // Next-state logic: synchronizer shift, edge detect and the two-state measurement FSM
    always_comb begin
        w_s1_d         = bus.sig_in;
        w_s_d          = r_s1_q;
        w_s_dly_d      = r_s_q;
        w_edge         = r_s_q & ~r_s_dly_q;

        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_hi_cnt_d     = r_hi_cnt_q;
        w_period_d     = r_period_q;
        w_high_time_d  = r_high_time_q;
        w_valid_d      = 1'b0;
        w_timeout_d    = r_timeout_q;
        w_meas_count_d = r_meas_count_q;

        case (r_state_q)
            c_WAIT_FIRST: begin
                // First edge only arms the counters; the edge cycle itself is high
                if (w_edge) begin
                    w_cnt_d    = c_ONE_W;
                    w_hi_cnt_d = c_ONE_W;
                    w_state_d  = c_MEASURE;
                end
            end
            c_MEASURE: begin
                if (w_edge) begin
                    // An edge wins over saturation, so a full-scale period still reports
                    w_period_d     = r_cnt_q;
                    w_high_time_d  = r_hi_cnt_q;
                    w_valid_d      = 1'b1;
                    w_timeout_d    = 1'b0;
                    w_meas_count_d = r_meas_count_q + c_ONE_N;
                    w_cnt_d        = c_ONE_W;
                    w_hi_cnt_d     = c_ONE_W;
                end else if (r_cnt_q == c_CNT_MAX) begin
                    // Counter would wrap: give up on this interval and re-arm
                    w_timeout_d = 1'b1;
                    w_state_d   = c_WAIT_FIRST;
                end else begin
                    w_cnt_d    = r_cnt_q + c_ONE_W;
                    w_hi_cnt_d = r_hi_cnt_q + {{(W-1){1'b0}}, r_s_q};
                end
            end
            default: begin
                w_state_d = c_WAIT_FIRST;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over all events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_q         <= 1'b0;
            r_s_q          <= 1'b0;
            r_s_dly_q      <= 1'b0;
            r_state_q      <= c_WAIT_FIRST;
            r_cnt_q        <= '0;
            r_hi_cnt_q     <= '0;
            r_period_q     <= '0;
            r_high_time_q  <= '0;
            r_valid_q      <= 1'b0;
            r_timeout_q    <= 1'b0;
            r_meas_count_q <= '0;
        end else begin
            r_s1_q         <= w_s1_d;
            r_s_q          <= w_s_d;
            r_s_dly_q      <= w_s_dly_d;
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_hi_cnt_q     <= w_hi_cnt_d;
            r_period_q     <= w_period_d;
            r_high_time_q  <= w_high_time_d;
            r_valid_q      <= w_valid_d;
            r_timeout_q    <= w_timeout_d;
            r_meas_count_q <= w_meas_count_d;
        end
    end

    assign bus.period     = r_period_q;
    assign bus.high_time  = r_high_time_q;
    assign bus.valid      = r_valid_q;
    assign bus.timeout    = r_timeout_q;
    assign bus.meas_count = r_meas_count_q;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_period_meter
//  Description : Self-checking bench for period_meter (W=4, N_WIDTH=2).
//                A reference model works on the recorded input history and
//                derives results from edge positions with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int TW  = 4;
    localparam int TN  = 2;
    localparam int MAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    period_meter_if #(.W(TW), .N_WIDTH(TN)) bus ();

    period_meter #(.W(TW), .N_WIDTH(TN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: input samples since reset and edge bookkeeping
    bit hist[$];
    bit armed;
    int t0;
    bit m_valid;
    bit m_timeout;
    int m_period;
    int m_high;
    int m_count;

    typedef struct {
        int period;
        int high;
        int count;
        int tmo;
    } vrec_t;
    vrec_t vlog[$];

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
        int exp_timeout;
    } vec_t;
    vec_t tbl[7];

    // Synchronized level in cycle c is the input sampled one edge earlier
    function automatic bit s_at(int c);
        int idx;
        idx = c - 1;
        if (idx >= 0 && idx < hist.size()) return hist[idx];
        return 1'b0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_vlog_period(string name, int idx, int exp_period, int exp_tmo);
        if (idx >= vlog.size()) begin
            checks++;
            failures++;
            $display("FAIL %s actual=missing required=period %0d", name, exp_period);
        end else begin
            chk({name, "_period"}, vlog[idx].period, exp_period);
            chk({name, "_timeout"}, vlog[idx].tmo, exp_tmo);
        end
    endtask

    // One clock: apply input/reset, advance the model, compare every output
    task automatic step(bit v, bit r);
        bus.sig_in = v;
        rst        = r;
        @(posedge clk);
        if (r) begin
            hist.delete();
            armed     = 1'b0;
            t0        = 0;
            m_valid   = 1'b0;
            m_timeout = 1'b0;
            m_period  = 0;
            m_high    = 0;
            m_count   = 0;
        end else begin
            int c;
            bit e;
            hist.push_back(v);
            c = hist.size() - 2;
            e = s_at(c) && !s_at(c - 1);
            m_valid = 1'b0;
            if (e) begin
                if (armed) begin
                    m_period = c - t0;
                    m_high   = 0;
                    for (int i = t0; i < c; i++) m_high += int'(s_at(i));
                    m_count   = (m_count + 1) % (1 << TN);
                    m_timeout = 1'b0;
                    m_valid   = 1'b1;
                end
                armed = 1'b1;
                t0    = c;
            end else if (armed && (c - t0) == MAX) begin
                armed     = 1'b0;
                m_timeout = 1'b1;
            end
        end
        #1;
        chk("valid",      int'(bus.valid),      int'(m_valid));
        chk("period",     int'(bus.period),     m_period);
        chk("high_time",  int'(bus.high_time),  m_high);
        chk("timeout",    int'(bus.timeout),    int'(m_timeout));
        chk("meas_count", int'(bus.meas_count), m_count);
        if (bus.valid === 1'b1)
            vlog.push_back('{int'(bus.period), int'(bus.high_time),
                             int'(bus.meas_count), int'(bus.timeout)});
    endtask

    task automatic wave(int hi, int lo, int reps);
        for (int k = 0; k < reps; k++) begin
            for (int j = 0; j < hi; j++) step(1'b1, 1'b0);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_cnt[5];
        bus.sig_in = 1'b0;

        tbl[0] = '{3, 3, 6,  6, 3, 0};
        tbl[1] = '{5, 5, 4, 10, 5, 0};
        tbl[2] = '{3, 3, 5,  6, 3, 0};
        tbl[3] = '{1, 1, 6,  2, 1, 0};
        tbl[4] = '{7, 8, 3, 15, 7, 0};
        tbl[5] = '{1, 4, 4,  5, 1, 0};
        tbl[6] = '{2,13, 3, 15, 2, 0};
        exp_cnt = '{1, 2, 3, 0, 1};

        // Reset state
        do_reset(2);
        chk("rst_period",     int'(bus.period),     0);
        chk("rst_high_time",  int'(bus.high_time),  0);
        chk("rst_valid",      int'(bus.valid),      0);
        chk("rst_timeout",    int'(bus.timeout),    0);
        chk("rst_meas_count", int'(bus.meas_count), 0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);

        // Table of square-wave segments, each ending with its settled result
        for (int i = 0; i < 7; i++) begin
            wave(tbl[i].hi, tbl[i].lo, tbl[i].reps);
            chk("tbl_period",    int'(bus.period),    tbl[i].exp_period);
            chk("tbl_high_time", int'(bus.high_time), tbl[i].exp_high);
            chk("tbl_timeout",   int'(bus.timeout),   tbl[i].exp_timeout);
        end

        // Timeout after one edge, then recovery: first edge re-arms only
        do_reset(1);
        vlog.delete();
        for (int k = 0; k < 3; k++)  step(1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b0);
        chk("to_flag",    int'(bus.timeout), 1);
        chk("to_novalid", vlog.size(),       0);
        wave(3, 3, 1);
        chk("to_rearm_flag",    int'(bus.timeout), 1);
        chk("to_rearm_novalid", vlog.size(),       0);
        wave(3, 3, 2);
        chk("to_nvalid", vlog.size(), 2);
        chk_vlog_period("to_first", 0, 6, 0);

        // Reset pulse in the middle of an interval discards the partial count
        do_reset(1);
        wave(3, 3, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("mid_rst_period",     int'(bus.period),     0);
        chk("mid_rst_valid",      int'(bus.valid),      0);
        chk("mid_rst_meas_count", int'(bus.meas_count), 0);
        vlog.delete();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        wave(3, 3, 1);
        chk("mid_rst_first_edge", vlog.size(), 0);
        wave(3, 3, 2);
        chk("mid_rst_nvalid", vlog.size(), 2);
        chk_vlog_period("mid_rst_first", 0, 6, 0);

        // Measurement counter wraps modulo 4
        do_reset(1);
        vlog.delete();
        wave(3, 3, 6);
        chk("wrap_nvalid", vlog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < vlog.size()) chk("wrap_count", vlog[k].count, exp_cnt[k]);
            else chk("wrap_count_missing", -1, exp_cnt[k]);
        end

        // Randomized segments with occasional long gaps and resets
        do_reset(1);
        for (int it = 0; it < 400; it++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 10));
            lo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 24))
                                             : int'($urandom_range(1, 10));
            wave(hi, lo, 1);
            if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(1, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter W, default 16: width of the period and high-time counters and outputs.
REQ-002 Parameter N_WIDTH, default 8: width of the measurement counter.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sig_in  input  1  signal under measurement (e.g. divided clock); asynchronous to clk.
REQ-006 period  output  W  clk cycles between the last two detected rising edges of sig_in.
REQ-007 high_time  output  W  clk cycles sig_in was seen high within that same interval.
REQ-008 valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 timeout  output  1  sticky flag: no rising edge seen within 2^W-1 cycles.
REQ-010 meas_count  output  N_WIDTH  number of valid measurements; wraps modulo 2^N_WIDTH.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, then s); a third register s_d holds the previous s.
REQ-012 A rising edge is detected when s=1 and s_d=0; that cycle is the "edge cycle".
REQ-013 The FSM SHALL have exactly two states: WAIT_FIRST and MEASURE. Reset enters WAIT_FIRST.
REQ-014 In WAIT_FIRST, an edge cycle SHALL set cnt to 1 and hi_cnt to 1, and move to MEASURE; no output changes.
REQ-015 In MEASURE, in a non-edge cycle: cnt += 1; hi_cnt += 1 if s=1, else it holds.
REQ-016 In MEASURE, an edge cycle SHALL load period with cnt and high_time with hi_cnt.
REQ-017 The same edge cycle SHALL set valid=1 on the next clk edge, clear timeout, and increment meas_count; then cnt←1 and hi_cnt←1.
REQ-018 Result: for edges at cycles t0 and t1, period = t1−t0 and high_time = the count of s=1 cycles in [t0, t1−1].
REQ-019 Latency: valid SHALL assert at the 3rd rising clk edge, counting the edge that first samples sig_in high as the 1st.
REQ-020 valid SHALL stay high for exactly one cycle per edge; period and high_time hold their values between updates.
REQ-021 Saturation: in MEASURE, if cnt = 2^W−1 in a non-edge cycle, then on that edge: timeout←1 and the FSM returns to WAIT_FIRST.
REQ-022 On saturation, period, high_time and meas_count SHALL be unchanged and no valid pulse SHALL be issued.
REQ-023 An edge cycle coinciding with cnt = 2^W−1 SHALL be treated as a normal measurement (REQ-016/017), not as a timeout.
REQ-024 timeout SHALL remain set until the next valid measurement or reset; the first edge after a timeout only re-arms the FSM (WAIT_FIRST behaviour).
REQ-025 hi_cnt SHALL never exceed cnt; the counters SHALL never wrap.
REQ-026 Minimum measurable period is 2 cycles. Pulses on sig_in shorter than 1 clk cycle may be missed; this is not an error.

Reset
REQ-027 rst=1 at a rising clk edge SHALL clear: s1, s, s_d, cnt, hi_cnt, period, high_time, valid, timeout and meas_count; FSM enters WAIT_FIRST.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count; the first edge after reset SHALL NOT produce valid.
REQ-029 Reset SHALL take priority over every simultaneous event (edge, saturation).

Verification
REQ-030 sig_in square wave, period 6 clk, high 3 -> first valid after the 2nd edge with period=6, high_time=3, meas_count=1; valid repeats every 6 cycles.
REQ-031 sig_in period 10, high 5, then switched to period 6, high 3 -> values 10/5 until the switch; the next valid reports the interval that spans the switch; all later valids report 6/3.
REQ-032 W=4, sig_in held low after one edge -> timeout=1 after 15 cycles, no valid. Resume period-6 wave -> first edge re-arms only; second edge gives valid, period=6, timeout=0.
REQ-033 Edge coinciding with cnt=2^W−1 (W=4, period 15) -> valid with period=15, timeout stays 0.
REQ-034 rst pulsed for 1 cycle mid-interval of a period-6 wave -> all outputs 0; first valid only after two post-reset edges, period=6.
REQ-035 N_WIDTH=2, 5 measurements -> meas_count sequence 1,2,3,0,1.
